// File: rtl/sfft_peak_picker.sv
// Sweeps each completed SFFT frame, keeps the PEAKS largest |bin| values in a sorted list,
// and hands them to the hash stage via valid/ack. Optional macro: SFFT_PEAK_SKIP_DC_EN.
module sfft_peak_picker #(
  parameter int FREQS      = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int AMPL_WIDTH = 32,
  parameter int PEAKS      = 4,
  parameter int TIME_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sfft_output_valid,
  input  logic                           sfft_read_error,
  input  logic signed [AMPL_WIDTH-1:0]   sfft_out_real,
  output logic [ADDR_WIDTH-1:0]          sfft_output_address,
  output logic                           sfft_output_being_read,
  output logic [PEAKS*ADDR_WIDTH-1:0]    peaks_bin,
  output logic [PEAKS*AMPL_WIDTH-1:0]    peaks_ampl,
  output logic [TIME_WIDTH-1:0]          peaks_time,
  output logic                           peaks_valid,
  input  logic                           peaks_ack,
  output logic                           frame_dropped
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, PRESENT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FREQS - 1);
  localparam logic [AMPL_WIDTH-1:0] AMAX = {1'b0, {(AMPL_WIDTH-1){1'b1}}};
  localparam logic [AMPL_WIDTH-1:0] AMIN = {1'b1, {(AMPL_WIDTH-1){1'b0}}};

  state_t                  state_q;
  logic                    vin_q, armed_q, bread_q, pvalid_q, drop_q, rd_vld_q;
  logic [ADDR_WIDTH-1:0]   addr_q, rd_bin_q;
  logic [TIME_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   bin_q  [PEAKS];
  logic [AMPL_WIDTH-1:0]   ampl_q [PEAKS];
  logic [ADDR_WIDTH-1:0]   bin_d  [PEAKS];
  logic [AMPL_WIDTH-1:0]   ampl_d [PEAKS];
  logic [PEAKS-1:0]        gt;
  logic [AMPL_WIDTH-1:0]   mag;
  logic                    rise, start, abort, ins_en;

  assign rise  = sfft_output_valid && !vin_q;
  assign start = (state_q == IDLE) && armed_q && sfft_output_valid;
  assign abort = ((state_q == READ) || (state_q == DRAIN)) &&
                 (sfft_read_error || !sfft_output_valid);

  always_comb begin
    if (sfft_out_real == AMIN)           mag = AMAX;
    else if (sfft_out_real[AMPL_WIDTH-1]) mag = -sfft_out_real;
    else                                 mag = sfft_out_real;
  end

`ifdef SFFT_PEAK_SKIP_DC_EN
  assign ins_en = rd_vld_q && (rd_bin_q != '0);
`else
  assign ins_en = rd_vld_q;
`endif

  // List is sorted descending, so gt is monotone: the new sample lands at the first
  // rank it strictly beats and everything below shifts down by one.
  genvar g;
  for (g = 0; g < PEAKS; g++) begin : g_rank
    assign gt[g] = mag > ampl_q[g];
    if (g == 0) begin : g_top
      assign bin_d[g]  = gt[g] ? rd_bin_q : bin_q[g];
      assign ampl_d[g] = gt[g] ? mag      : ampl_q[g];
    end else begin : g_rest
      assign bin_d[g]  = gt[g-1] ? bin_q[g-1]  : (gt[g] ? rd_bin_q : bin_q[g]);
      assign ampl_d[g] = gt[g-1] ? ampl_q[g-1] : (gt[g] ? mag      : ampl_q[g]);
    end
    assign peaks_bin[g*ADDR_WIDTH +: ADDR_WIDTH]  = bin_q[g];
    assign peaks_ampl[g*AMPL_WIDTH +: AMPL_WIDTH] = ampl_q[g];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      vin_q    <= 1'b0;
      armed_q  <= 1'b0;
      bread_q  <= 1'b0;
      pvalid_q <= 1'b0;
      drop_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      addr_q   <= '0;
      rd_bin_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < PEAKS; i++) begin
        bin_q[i]  <= '0;
        ampl_q[i] <= '0;
      end
    end else begin
      vin_q    <= sfft_output_valid;
      drop_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      if (rise) armed_q <= 1'b1;
      // A second edge before the pending frame starts means that frame was overwritten.
      if (rise && armed_q && !start) drop_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= READ;
          armed_q <= 1'b0;
          addr_q  <= '0;
          bread_q <= 1'b1;
          for (int i = 0; i < PEAKS; i++) begin
            bin_q[i]  <= '0;
            ampl_q[i] <= '0;
          end
        end
        READ, DRAIN: if (abort) begin
          state_q <= IDLE;
          bread_q <= 1'b0;
          drop_q  <= 1'b1;
          addr_q  <= '0;
          cnt_q   <= cnt_q + 1'b1;
          for (int i = 0; i < PEAKS; i++) begin
            bin_q[i]  <= '0;
            ampl_q[i] <= '0;
          end
        end else begin
          if (ins_en) begin
            for (int i = 0; i < PEAKS; i++) begin
              bin_q[i]  <= bin_d[i];
              ampl_q[i] <= ampl_d[i];
            end
          end
          if (state_q == READ) begin
            rd_vld_q <= 1'b1;
            rd_bin_q <= addr_q;
            if (addr_q == LAST) state_q <= DRAIN;
            else                addr_q  <= addr_q + 1'b1;
          end else begin
            state_q  <= PRESENT;
            bread_q  <= 1'b0;
            pvalid_q <= 1'b1;
            addr_q   <= '0;
          end
        end
        PRESENT: if (peaks_ack) begin
          state_q  <= IDLE;
          pvalid_q <= 1'b0;
          cnt_q    <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sfft_output_address    = addr_q;
  assign sfft_output_being_read = bread_q;
  assign peaks_time             = cnt_q;
  assign peaks_valid            = pvalid_q;
  assign frame_dropped          = drop_q;

endmodule

// File: tb/tb_sfft_peak_picker.sv
// Directed-vector bench for sfft_peak_picker with a registered-read model of the SFFT buffer.
module tb_sfft_peak_picker;

  logic         clk = 1'b0;
  logic         reset, valid, err, ack;
  logic [31:0]  rdata;
  logic [4:0]   addr;
  logic         bread, pv, drop;
  logic [19:0]  pbin;
  logic [127:0] pampl;
  logic [31:0]  ptime;
  logic [31:0]  mem [32];
  int           pass = 0, total = 0;

  sfft_peak_picker dut (
    .clk(clk), .reset(reset), .sfft_output_valid(valid), .sfft_read_error(err),
    .sfft_out_real(rdata), .sfft_output_address(addr), .sfft_output_being_read(bread),
    .peaks_bin(pbin), .peaks_ampl(pampl), .peaks_time(ptime), .peaks_valid(pv),
    .peaks_ack(ack), .frame_dropped(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[addr];

  task automatic clear_mem();
    for (int k = 0; k < 32; k++) mem[k] = 32'd0;
  endtask

  task automatic load_ramp();
    clear_mem();
    for (int k = 0; k < 16; k++) mem[k] = 32'(10 * k);
  endtask

  task automatic do_reset();
    reset = 1'b0; valid = 1'b0; err = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Returns at the negedge just after the edge that sees the rising valid.
  task automatic trigger();
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pv(output int n);
    n = 0;
    while (!pv && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!pv) $display("FAIL peaks_valid_timeout: got 0 want 1 within 60 cycles");
    else pass++;
  endtask

  task automatic wait_addr(input logic [4:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (addr == a && bread) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({addr, bread, pv, drop} !== 8'd0) $display("FAIL reset_ctrl: got %0h want 0", {addr, bread, pv, drop});
    else pass++;
    total++;
    if ({pbin, pampl, ptime} !== '0) $display("FAIL reset_list: got %0h/%0h/%0h want 0", pbin, pampl, ptime);
    else pass++;
  endtask

  task automatic test_ramp();
    int n, drops;
    logic [19:0]  b0;
    logic [127:0] a0;
    bit stable;
    load_ramp();
    trigger();
    wait_pv(n);
    total++;
    if (n !== 18) $display("FAIL ramp_latency: got %0d want 18", n);
    else pass++;
    total++;
    if (pbin !== {5'd12, 5'd13, 5'd14, 5'd15}) $display("FAIL ramp_bins: got %h want %h", pbin, {5'd12, 5'd13, 5'd14, 5'd15});
    else pass++;
    total++;
    if (pampl !== {32'd120, 32'd130, 32'd140, 32'd150}) $display("FAIL ramp_ampl: got %h", pampl);
    else pass++;
    total++;
    if (ptime !== 32'd0) $display("FAIL ramp_time: got %0d want 0", ptime);
    else pass++;
    // Hold ack low; re-arm once (no drop) then edge again (drop) while presenting.
    b0 = pbin; a0 = pampl; stable = 1'b1; drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pbin !== b0 || pampl !== a0 || !pv || ptime !== 32'd0) stable = 1'b0;
      if (drop) drops++;
      if (i == 0) begin
        clear_mem();
        mem[3] = 32'hFFFF_FF38;
        mem[7] = 32'd100;
        mem[9] = 32'h8000_0000;
      end
      if (i == 2 || i == 4) valid = 1'b0;
      if (i == 3 || i == 5) valid = 1'b1;
    end
    total++;
    if (!stable) $display("FAIL ramp_hold_stable: got unstable want stable");
    else pass++;
    total++;
    if (drops !== 1) $display("FAIL second_edge_drop: got %0d pulses want 1", drops);
    else pass++;
    do_ack();
    total++;
    if (pv !== 1'b0 || ptime !== 32'd1) $display("FAIL ack_accept: got pv=%0b time=%0d want 0/1", pv, ptime);
    else pass++;
  endtask

  // Armed during PRESENT above, so this frame starts without a new edge.
  task automatic test_signed();
    int n;
    wait_pv(n);
    total++;
    if (pbin !== {5'd0, 5'd7, 5'd3, 5'd9}) $display("FAIL signed_bins: got %h want %h", pbin, {5'd0, 5'd7, 5'd3, 5'd9});
    else pass++;
    total++;
    if (pampl !== {32'd0, 32'd100, 32'd200, 32'h7FFF_FFFF}) $display("FAIL signed_ampl: got %h", pampl);
    else pass++;
    total++;
    if (ptime !== 32'd1) $display("FAIL signed_time: got %0d want 1", ptime);
    else pass++;
    do_ack();
  endtask

  task automatic test_ties();
    int n;
    logic [4:0] r3;
`ifdef SFFT_PEAK_SKIP_DC_EN
    r3 = 5'd1;
`else
    r3 = 5'd0;
`endif
    for (int k = 0; k < 32; k++) mem[k] = 32'd1;
    mem[2] = 32'd50; mem[5] = 32'd50; mem[11] = 32'd50;
    trigger();
    wait_pv(n);
    total++;
    if (pbin !== {r3, 5'd11, 5'd5, 5'd2}) $display("FAIL ties_bins: got %h want %h", pbin, {r3, 5'd11, 5'd5, 5'd2});
    else pass++;
    total++;
    if (pampl !== {32'd1, 32'd50, 32'd50, 32'd50} || ptime !== 32'd2) $display("FAIL ties_ampl_time: got %h/%0d", pampl, ptime);
    else pass++;
    do_ack();
  endtask

  task automatic test_abort();
    int n, pvs;
    bit ok;
    do_reset();
    load_ramp();
    trigger();
    wait_addr(5'd6, ok);
    total++;
    if (!ok) $display("FAIL abort_reach_addr6: got timeout want addr 6");
    else pass++;
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    total++;
    if (drop !== 1'b1 || bread !== 1'b0) $display("FAIL abort_pulse: got drop=%0b bread=%0b want 1/0", drop, bread);
    else pass++;
    pvs = 0;
    @(negedge clk);
    total++;
    if (drop !== 1'b0) $display("FAIL abort_pulse_width: got %0b want 0", drop);
    else pass++;
    for (int i = 0; i < 25; i++) begin
      if (pv) pvs++;
      @(negedge clk);
    end
    total++;
    if (pvs !== 0) $display("FAIL abort_no_valid: got %0d want 0", pvs);
    else pass++;
    trigger();
    wait_pv(n);
    total++;
    if (ptime !== 32'd1 || pbin !== {5'd12, 5'd13, 5'd14, 5'd15}) $display("FAIL after_abort: got time=%0d bins=%h want 1", ptime, pbin);
    else pass++;
    do_ack();
  endtask

  task automatic test_midreset();
    int n;
    bit ok;
    load_ramp();
    trigger();
    wait_addr(5'd9, ok);
    total++;
    if (!ok) $display("FAIL midreset_reach_addr9: got timeout want addr 9");
    else pass++;
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    total++;
    if ({addr, bread, pv, drop} !== 8'd0 || {pbin, pampl, ptime} !== '0) $display("FAIL midreset_outputs: got %h %h %h", {addr, bread, pv, drop}, pbin, ptime);
    else pass++;
    reset = 1'b1;
    trigger();
    @(negedge clk);
    total++;
    if (addr !== 5'd0 || bread !== 1'b1) $display("FAIL restart_addr0: got addr=%0d bread=%0b want 0/1", addr, bread);
    else pass++;
    wait_pv(n);
    total++;
    if (ptime !== 32'd0 || pampl[31:0] !== 32'd150) $display("FAIL restart_result: got time=%0d r0=%0d want 0/150", ptime, pampl[31:0]);
    else pass++;
    do_ack();
  endtask

  task automatic test_option();
    int n;
    logic [4:0]  eb;
    logic [31:0] ea;
`ifdef SFFT_PEAK_SKIP_DC_EN
    eb = 5'd4; ea = 32'd10;
`else
    eb = 5'd0; ea = 32'd1000;
`endif
    clear_mem();
    mem[0] = 32'd1000; mem[4] = 32'd10;
    trigger();
    wait_pv(n);
    total++;
    if (pbin[4:0] !== eb || pampl[31:0] !== ea) $display("FAIL dc_rank0: got {%0d,%0d} want {%0d,%0d}", pbin[4:0], pampl[31:0], eb, ea);
    else pass++;
    do_ack();
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_ramp();
    test_signed();
    test_ties();
    test_abort();
    test_midreset();
    test_option();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/sfft_peak_picker.md
Name: sfft_peak_picker

Overview:
- Downstream consumer of the SFFT pipeline's output buffer.
- When a new spectrum frame becomes valid, it sweeps the read address over bins 0..FREQS-1 and takes the absolute value of each real output.
- It keeps the PEAKS largest bins in a sorted register list.
- It presents the bin indices, amplitudes and a frame timestamp to the fingerprint/hash stage through a valid/ack handshake.

Parameters:
FREQS, 16, number of bins swept per frame (NFFT/2)
ADDR_WIDTH, 5, width of the SFFT output address (nFFT)
AMPL_WIDTH, 32, width of the SFFT real output (SFFT_OUTPUT_WIDTH)
PEAKS, 4, number of peaks retained per frame (>=1)
TIME_WIDTH, 32, frame timestamp width (TIME_COUNTER_WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
sfft_output_valid  in  1  SFFT output buffer holds a complete frame (level)
sfft_read_error  in  1  SFFT reports the buffer was overwritten during our read
sfft_out_real  in  AMPL_WIDTH  signed two's-complement bin value; registered read, valid 1 cycle after address
sfft_output_address  out  ADDR_WIDTH  bin being read
sfft_output_being_read  out  1  read in progress; SFFT must not swap buffers
peaks_bin  out  PEAKS*ADDR_WIDTH  bin index per rank; rank 0 = largest, in LSBs
peaks_ampl  out  PEAKS*AMPL_WIDTH  unsigned magnitude per rank; same packing
peaks_time  out  TIME_WIDTH  index of the frame these peaks belong to
peaks_valid  out  1  peak set available; held until accepted
peaks_ack  in  1  consumer accepts the peak set
frame_dropped  out  1  one-cycle pulse when a frame is aborted or skipped

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE. All outputs 0; list entries {bin 0, ampl 0}; frame counter 0; armed flag 0. Applies mid-operation; no partial result survives.
- Arming:
  - A rising edge of sfft_output_valid (compare with a registered copy) sets armed.
  - In IDLE with armed=1 and sfft_output_valid=1, the block clears the list and armed, and enters READ.
  - A rising edge while in PRESENT leaves armed set; the frame is processed after ack, if still valid.
  - A second rising edge before that frame starts pulses frame_dropped and keeps armed=1.
- READ (FREQS cycles):
  - sfft_output_address counts 0..FREQS-1, one per cycle.
  - sfft_output_being_read=1 from the first READ cycle through DRAIN.
  - Data for address k is sampled on the cycle after it is presented.
- DRAIN (1 cycle): samples the final bin, deasserts being_read, then moves to PRESENT.
- Magnitude: |x| in AMPL_WIDTH bits; the most-negative input saturates to 2^(AMPL_WIDTH-1)-1.
- Insertion:
  - Each sample is compared in parallel with all entries.
  - The new value goes to the first rank whose amplitude is strictly less; lower ranks shift down and the last rank is discarded.
  - Ties keep the earlier (lower) bin at the higher rank.
  - Zero-magnitude samples never insert; unused ranks stay {0,0}.
- PRESENT:
  - peaks_valid=1 with peaks_time = frame counter; outputs stable until peaks_valid&&peaks_ack.
  - On that edge: peaks_valid->0, frame counter +1 (wraps at 2^TIME_WIDTH), state IDLE.
  - peaks_ack outside PRESENT is ignored.
- Latency: trigger seen at cycle T; address k presented at T+1+k; peaks_valid rises at T+FREQS+2.
- Abort: sfft_read_error=1, or sfft_output_valid=0, during READ/DRAIN gives:
  - a one-cycle frame_dropped pulse;
  - list cleared, being_read->0, state IDLE;
  - no peaks_valid, and the frame counter still increments.
- Simultaneous events:
  - Abort has priority over the final DRAIN transition.
  - A new rising edge in the same cycle as ack sets armed normally.

Optional Feature:
SFFT_PEAK_SKIP_DC_EN:
- Defined: bin 0 is read but never inserted, so DC offset cannot occupy a rank; latency unchanged.
- Undefined: bin 0 competes like any other bin.

Test Plan:
- Ramp and backpressure: FREQS=16, PEAKS=4, bin k value 10*k, ack held low 20 cycles.
  - peaks_bin = {15,14,13,12}, peaks_ampl = {150,140,130,120}, peaks_time=0.
  - peaks_valid rises exactly 18 cycles after the trigger and outputs stay stable until ack.
- Signed values: bin3=-200, bin7=100, bin9=-32'h80000000, others 0.
  - Ranks = {9:0x7FFFFFFF, 3:200, 7:100, 0:0}.
- Ties: bins 2, 5 and 11 all = 50, others 1.
  - Ranks = {2,5,11,x} with the lower bin first; rank 3 holds the lowest-indexed bin of value 1.
- Abort: sfft_read_error pulsed while address=6.
  - frame_dropped pulses one cycle and being_read drops; no peaks_valid.
  - The next frame reports peaks_time=1.
- Reset: reset low during READ at address 9.
  - Next cycle all outputs 0 and state IDLE; a fresh rising edge of sfft_output_valid restarts from address 0 with peaks_time=0.
- Option: with SFFT_PEAK_SKIP_DC_EN, bin0=1000 and bin4=10, others 0 gives rank0 = {4,10}; without the macro, rank0 = {0,1000}.
